// File: rtl/cli_char_feeder.sv
// rtl/cli_char_feeder.sv - character feeder: input FIFO, write strobe, cursor advance and newline expansion
module cli_char_feeder #(
   parameter int         DEPTH   = 8,
   parameter int         COLS    = 80,
   parameter logic [3:0] NL_CODE = 4'hF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               in_char,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [3:0]               new_char,
   output logic                     text_en,
   output logic                     btn_pressed,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [6:0]               col
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int NW = $clog2(COLS + 1);

   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [6:0]    COL_LAST = 7'(COLS - 1);
   localparam logic [6:0]    COLS_W   = 7'(COLS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] ADV   = 2'd2;
   localparam logic [1:0] NL    = 2'd3;

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [NW-1:0] nl_left;
   logic [CW-1:0] count_nxt;
   logic [6:0]    col_inc;
   logic [3:0]    head;
   logic          push;
   logic          pop;

   assign head    = mem[rd_ptr];
   assign push    = in_valid & in_ready;
   assign pop     = (state == IDLE) && (fifo_count != '0);
   assign col_inc = (col == COL_LAST) ? 7'd0 : col + 7'd1;

   always_comb begin
      count_nxt = fifo_count + CW'(push) - CW'(pop);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pop) state_nxt = (head == NL_CODE) ? NL : WRITE;
         WRITE:   state_nxt = ADV;
         ADV:     state_nxt = IDLE;
         NL:      if (nl_left == NW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Storage has no reset; only the pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_char;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         new_char    <= 4'd0;
         text_en     <= 1'b0;
         btn_pressed <= 1'b0;
         col         <= 7'd0;
         nl_left     <= '0;
      end else begin
         state       <= state_nxt;
         fifo_count  <= count_nxt;
         in_ready    <= (count_nxt != FULL);
         busy        <= (state_nxt != IDLE) || (count_nxt != '0);
         text_en     <= (state == WRITE);
         btn_pressed <= (state == ADV) || (state == NL);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            if (head != NL_CODE) new_char <= head;
            else                 nl_left  <= NW'(COLS_W - col);
         end
         if ((state == ADV) || (state == NL)) col <= col_inc;
         if (state == NL) nl_left <= nl_left - NW'(1);
      end
   end

endmodule

// File: tb/tb_cli_char_feeder.sv
// tb/tb_cli_char_feeder.sv - directed self-checking bench for cli_char_feeder
module tb_cli_char_feeder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in_char = 4'd0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] new_char;
   logic       text_en;
   logic       btn_pressed;
   logic       busy;
   logic [3:0] fifo_count;
   logic [6:0] col;

   int checks = 0;
   int failures = 0;

   int te_cnt = 0, bp_cnt = 0, both_cnt = 0, run = 0, last_run = 0;
   int max_cnt = 0, full_seen = 0, ovf = 0, max_col = 0, colbad = 0;
   logic [3:0] hist [0:511];

   always #5 clk = ~clk;

   cli_char_feeder #(.DEPTH(8), .COLS(80), .NL_CODE(4'hF)) dut (
      .clk(clk), .rst(rst), .in_char(in_char), .in_valid(in_valid),
      .in_ready(in_ready), .new_char(new_char), .text_en(text_en),
      .btn_pressed(btn_pressed), .busy(busy), .fifo_count(fifo_count), .col(col)
   );

   always @(negedge clk) begin
      if (rst) begin
         run = 0;
      end else begin
         if (text_en) begin
            hist[te_cnt % 512] = new_char;
            te_cnt++;
         end
         if (text_en && btn_pressed) both_cnt++;
         if (btn_pressed) begin
            bp_cnt++;
            run++;
         end else if (run > 0) begin
            last_run = run;
            run = 0;
         end
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         if (fifo_count == 4'd8 && !in_ready) full_seen++;
         if ((fifo_count == 4'd8 && in_ready) || fifo_count > 4'd8) ovf++;
         if (int'(col) > max_col) max_col = int'(col);
         if (col >= 7'd80) colbad++;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic push(input logic [3:0] c);
      int n = 0;
      @(negedge clk);
      in_char  = c;
      in_valid = 1'b1;
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("push_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || btn_pressed || text_en) && n < 5000);
      if (n >= 5000) check("idle_timeout", 0, 1);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_text_en"}, int'(text_en), 0);
      check({tag, "_btn"}, int'(btn_pressed), 0);
      check({tag, "_new_char"}, int'(new_char), 0);
      check({tag, "_col"}, int'(col), 0);
      check({tag, "_count"}, int'(fifo_count), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_in_ready"}, int'(in_ready), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int base, bp0, nl_pulses, n;

      #1 check_reset_outputs("por");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 check("por_ready_before_edge", int'(in_ready), 0);
      @(negedge clk);
      check("por_ready_after_edge", int'(in_ready), 1);

      // mid-stream reset
      for (int i = 0; i < 4; i++) push(4'(i + 4));
      @(negedge clk);
      rst = 1'b1;
      #1 check_reset_outputs("mid");
      @(negedge clk);
      check("mid_ready_held", int'(in_ready), 0);
      rst = 1'b0;
      #1 check("mid_ready_release", int'(in_ready), 0);
      base = te_cnt;
      bp0  = bp_cnt;
      @(negedge clk);
      check("mid_ready_one_cycle", int'(in_ready), 1);
      repeat (20) @(negedge clk);
      #1 check("mid_no_resume_te", te_cnt - base, 0);
      check("mid_no_resume_bp", bp_cnt - bp0, 0);

      // single character, cycle-exact latency
      base = te_cnt;
      bp0  = bp_cnt;
      @(negedge clk);
      in_char  = 4'h3;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("one_count_e0", int'(fifo_count), 1);
      check("one_busy_e0", int'(busy), 1);
      @(negedge clk);
      check("one_te_e1", int'(text_en), 0);
      check("one_count_e1", int'(fifo_count), 0);
      @(negedge clk);
      check("one_te_e2", int'(text_en), 1);
      check("one_char_e2", int'(new_char), 3);
      check("one_btn_e2", int'(btn_pressed), 0);
      check("one_busy_e2", int'(busy), 1);
      @(negedge clk);
      check("one_btn_e3", int'(btn_pressed), 1);
      check("one_te_e3", int'(text_en), 0);
      check("one_col_e3", int'(col), 1);
      check("one_busy_e3", int'(busy), 0);
      @(negedge clk);
      check("one_btn_e4", int'(btn_pressed), 0);
      #1 check("one_te_total", te_cnt - base, 1);
      check("one_bp_total", bp_cnt - bp0, 1);

      // back-to-back burst that fills the FIFO and stalls the CPU
      base = te_cnt;
      for (int i = 0; i < 14; i++) push(4'(i));
      wait_idle();
      check("burst_max_count", max_cnt, 8);
      check("burst_full_seen", int'(full_seen > 0), 1);
      check("burst_overflow", ovf, 0);
      check("burst_te_total", te_cnt - base, 14);
      for (int i = 0; i < 14; i++) check($sformatf("burst_order%0d", i), int'(hist[base + i]), i);
      check("burst_col", int'(col), 15);

      // newline at column 5, then at column 0
      do_reset();
      base = te_cnt;
      bp0  = bp_cnt;
      for (int i = 0; i < 5; i++) push(4'h1);
      push(4'hF);
      wait_idle();
      check("nl5_te_total", te_cnt - base, 5);
      check("nl5_bp_total", bp_cnt - bp0, 80);
      check("nl5_run", last_run, 75);
      check("nl5_col", int'(col), 0);
      base = te_cnt;
      bp0  = bp_cnt;
      push(4'hF);
      wait_idle();
      check("nl0_te_total", te_cnt - base, 0);
      check("nl0_run", last_run, 80);
      check("nl0_bp_total", bp_cnt - bp0, 80);
      check("nl0_col", int'(col), 0);

      // a full line of characters wraps the column
      base = te_cnt;
      bp0  = bp_cnt;
      for (int i = 0; i < 80; i++) push(4'(i % 15));
      wait_idle();
      check("line_te_total", te_cnt - base, 80);
      check("line_bp_total", bp_cnt - bp0, 80);
      check("line_col", int'(col), 0);
      check("line_max_col", max_col, 79);
      check("line_order79", int'(hist[base + 79]), 79 % 15);

      // reset during a newline with 40 pulses left
      push(4'hF);
      nl_pulses = 0;
      n = 0;
      while (nl_pulses < 40 && n < 500) begin
         @(negedge clk);
         if (btn_pressed) nl_pulses++;
         n++;
      end
      if (n >= 500) check("nl_rst_timeout", 0, 1);
      rst = 1'b1;
      #1 check("nlrst_btn", int'(btn_pressed), 0);
      check("nlrst_count", int'(fifo_count), 0);
      check("nlrst_col", int'(col), 0);
      check("nlrst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 bp0 = bp_cnt;
      repeat (100) @(negedge clk);
      #1 check("nlrst_no_residual", bp_cnt - bp0, 0);
      check("nlrst_col_after", int'(col), 0);

      check("never_both", both_cnt, 0);
      check("col_in_range", colbad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "global timeout");
   end

endmodule
